// File: rtl/ld_step_counter.sv
// Loadable up/down step counter with wrap/saturate arithmetic and an autonomous
// countdown mode (IDLE/RUN) reporting busy and a one-cycle done pulse.
module ld_step_counter #(
    parameter int WIDTH    = 16,
    parameter int STEP     = 1,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             start,
    input  logic             inc,
    input  logic             dec,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH:0] STEP_X = (WIDTH+1)'(STEP);

    state_t           r_state;
    logic [WIDTH-1:0] r_dout;
    logic             r_zero;
    logic             r_busy;
    logic             r_done;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_inc_val;
    logic [WIDTH-1:0] w_dec_val;
    logic             w_tick_last;
    logic [WIDTH-1:0] w_dout_nxt;

    // One extra bit exposes carry/borrow for the saturate decision.
    assign w_sum       = {1'b0, r_dout} + STEP_X;
    assign w_diff      = {1'b0, r_dout} - STEP_X;
    assign w_inc_val   = (SATURATE && w_sum[WIDTH])  ? {WIDTH{1'b1}} : w_sum[WIDTH-1:0];
    assign w_dec_val   = (SATURATE && w_diff[WIDTH]) ? {WIDTH{1'b0}} : w_diff[WIDTH-1:0];
    assign w_tick_last = ({1'b0, r_dout} <= STEP_X);

    always_comb begin
        w_dout_nxt = r_dout;
        if (load || start) begin
            w_dout_nxt = din;
        end else if (r_state == ST_RUN) begin
            w_dout_nxt = w_tick_last ? {WIDTH{1'b0}} : w_diff[WIDTH-1:0];
        end else if (inc && !dec) begin
            w_dout_nxt = w_inc_val;
        end else if (dec && !inc) begin
            w_dout_nxt = w_dec_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_dout  <= '0;
            r_zero  <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_dout <= w_dout_nxt;
            r_zero <= (w_dout_nxt == '0);
            r_done <= 1'b0;
            if (load) begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
            end else if (start) begin
                // A zero start completes immediately rather than entering RUN.
                if (din != '0) begin
                    r_state <= ST_RUN;
                    r_busy  <= 1'b1;
                end else begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
            end else if (r_state == ST_RUN && w_tick_last) begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
            end
        end
    end

    assign dout = r_dout;
    assign zero = r_zero;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_ld_step_counter.sv
// Directed bench for ld_step_counter: default, saturating and STEP=4 instances
// driven side by side, checking {dout, zero, busy, done} after each edge.
module tb_ld_step_counter;

    logic clk;
    logic rst_n;

    logic        a_load, a_start, a_inc, a_dec;
    logic [15:0] a_din, a_dout;
    logic        a_zero, a_busy, a_done;

    logic        s_load, s_start, s_inc, s_dec;
    logic [15:0] s_din, s_dout;
    logic        s_zero, s_busy, s_done;

    logic        f_load, f_start, f_inc, f_dec;
    logic [15:0] f_din, f_dout;
    logic        f_zero, f_busy, f_done;

    int n_vec;
    int n_err;

    ld_step_counter #(.WIDTH(16), .STEP(1), .SATURATE(1'b0)) u_a (
        .clk(clk), .rst_n(rst_n), .load(a_load), .start(a_start), .inc(a_inc), .dec(a_dec),
        .din(a_din), .dout(a_dout), .zero(a_zero), .busy(a_busy), .done(a_done));

    ld_step_counter #(.WIDTH(16), .STEP(1), .SATURATE(1'b1)) u_s (
        .clk(clk), .rst_n(rst_n), .load(s_load), .start(s_start), .inc(s_inc), .dec(s_dec),
        .din(s_din), .dout(s_dout), .zero(s_zero), .busy(s_busy), .done(s_done));

    ld_step_counter #(.WIDTH(16), .STEP(4), .SATURATE(1'b0)) u_f (
        .clk(clk), .rst_n(rst_n), .load(f_load), .start(f_start), .inc(f_inc), .dec(f_dec),
        .din(f_din), .dout(f_dout), .zero(f_zero), .busy(f_busy), .done(f_done));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        {a_load, a_start, a_inc, a_dec} = 4'b0;
        {s_load, s_start, s_inc, s_dec} = 4'b0;
        {f_load, f_start, f_inc, f_dec} = 4'b0;
    endtask

    task automatic test_reset();
        logic [18:0] exp_v;
        exp_v = {16'h0000, 1'b1, 1'b0, 1'b0};
        n_vec++;
        if ({a_dout, a_zero, a_busy, a_done} !== exp_v) begin
            $display("FAIL reset_a: got %h expected %h", {a_dout, a_zero, a_busy, a_done}, exp_v);
            n_err++;
        end
        n_vec++;
        if ({f_dout, f_zero, f_busy, f_done} !== exp_v) begin
            $display("FAIL reset_f: got %h expected %h", {f_dout, f_zero, f_busy, f_done}, exp_v);
            n_err++;
        end
    endtask

    task automatic test_load_manual();
        logic [15:0] exp_d [5] = '{16'd5, 16'd4, 16'd3, 16'd4, 16'd4};
        a_load = 1'b1; a_din = 16'h0005;
        tick();
        a_load = 1'b0;
        n_vec++;
        if ({a_dout, a_zero, a_busy} !== {exp_d[0], 1'b0, 1'b0}) begin
            $display("FAIL load5: got dout=%h zero=%b busy=%b expected %h", a_dout, a_zero, a_busy, exp_d[0]);
            n_err++;
        end
        for (int i = 1; i < 5; i++) begin
            a_dec = (i == 1 || i == 2 || i == 4);
            a_inc = (i == 3 || i == 4);
            tick();
            n_vec++;
            if (a_dout !== exp_d[i]) begin
                $display("FAIL manual_op%0d: got %h expected %h", i, a_dout, exp_d[i]);
                n_err++;
            end
        end
        idle_all();
    endtask

    task automatic test_wrap_saturate();
        a_load = 1'b1; a_din = 16'h0000;
        s_load = 1'b1; s_din = 16'h0000;
        tick();
        a_load = 1'b0; a_dec = 1'b1;
        s_load = 1'b0; s_dec = 1'b1;
        tick();
        n_vec++;
        if ({a_dout, a_zero} !== {16'hFFFF, 1'b0}) begin
            $display("FAIL wrap_dec: got %h zero=%b expected FFFF zero=0", a_dout, a_zero);
            n_err++;
        end
        n_vec++;
        if ({s_dout, s_zero} !== {16'h0000, 1'b1}) begin
            $display("FAIL sat_dec: got %h zero=%b expected 0000 zero=1", s_dout, s_zero);
            n_err++;
        end
        a_dec = 1'b0; a_inc = 1'b1;
        s_dec = 1'b0; s_load = 1'b1; s_din = 16'hFFFF;
        tick();
        n_vec++;
        if ({a_dout, a_zero} !== {16'h0000, 1'b1}) begin
            $display("FAIL wrap_inc: got %h zero=%b expected 0000 zero=1", a_dout, a_zero);
            n_err++;
        end
        s_load = 1'b0; s_inc = 1'b1;
        a_inc = 1'b0;
        tick();
        n_vec++;
        if (s_dout !== 16'hFFFF) begin
            $display("FAIL sat_inc: got %h expected FFFF", s_dout);
            n_err++;
        end
        s_inc = 1'b0; s_load = 1'b1; s_din = 16'h0002;
        tick();
        s_load = 1'b0; s_dec = 1'b1;
        tick();
        n_vec++;
        if (s_dout !== 16'h0001) begin
            $display("FAIL sat_dec_normal: got %h expected 0001", s_dout);
            n_err++;
        end
        idle_all();
    endtask

    task automatic test_countdown();
        logic [15:0] exp_d [4] = '{16'd3, 16'd2, 16'd1, 16'd0};
        logic        exp_b [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic        exp_o [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        a_start = 1'b1; a_din = 16'd3;
        tick();
        a_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if ({a_dout, a_busy, a_done, a_zero} !== {exp_d[i], exp_b[i], exp_o[i], exp_d[i] == 16'd0}) begin
                $display("FAIL countdown%0d: got dout=%h busy=%b done=%b expected dout=%h busy=%b done=%b",
                         i, a_dout, a_busy, a_done, exp_d[i], exp_b[i], exp_o[i]);
                n_err++;
            end
            tick();
        end
        n_vec++;
        if ({a_dout, a_busy, a_done} !== {16'd0, 1'b0, 1'b0}) begin
            $display("FAIL countdown_after: got dout=%h busy=%b done=%b expected 0000 0 0", a_dout, a_busy, a_done);
            n_err++;
        end
    endtask

    task automatic test_step4();
        logic [15:0] exp_d [4] = '{16'd10, 16'd6, 16'd2, 16'd0};
        int done_cnt;
        done_cnt = 0;
        f_start = 1'b1; f_din = 16'd10;
        tick();
        f_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (f_done) done_cnt++;
            n_vec++;
            if ({f_dout, f_busy} !== {exp_d[i], i != 3}) begin
                $display("FAIL step4_run%0d: got dout=%h busy=%b expected dout=%h", i, f_dout, f_busy, exp_d[i]);
                n_err++;
            end
            tick();
        end
        if (f_done) done_cnt++;
        n_vec++;
        if ({done_cnt, f_zero} !== {32'd1, 1'b1}) begin
            $display("FAIL step4_done: got done_count=%0d zero=%b expected 1 1", done_cnt, f_zero);
            n_err++;
        end
        f_start = 1'b1; f_din = 16'd0;
        tick();
        f_start = 1'b0;
        n_vec++;
        if ({f_dout, f_busy, f_done} !== {16'd0, 1'b0, 1'b1}) begin
            $display("FAIL step4_start0: got dout=%h busy=%b done=%b expected 0000 0 1", f_dout, f_busy, f_done);
            n_err++;
        end
        tick();
        n_vec++;
        if ({f_busy, f_done} !== 2'b00) begin
            $display("FAIL step4_start0_after: got busy=%b done=%b expected 0 0", f_busy, f_done);
            n_err++;
        end
        f_load = 1'b1; f_din = 16'd3;
        tick();
        f_load = 1'b0; f_inc = 1'b1;
        tick();
        n_vec++;
        if (f_dout !== 16'd7) begin
            $display("FAIL step4_inc: got %h expected 0007", f_dout);
            n_err++;
        end
        f_inc = 1'b0; f_dec = 1'b1;
        tick();
        tick();
        n_vec++;
        if (f_dout !== 16'hFFFF) begin
            $display("FAIL step4_dec_wrap: got %h expected FFFF", f_dout);
            n_err++;
        end
        idle_all();
    endtask

    task automatic test_priority();
        a_start = 1'b1; a_din = 16'd5;
        tick();
        a_start = 1'b0; a_dec = 1'b1;
        tick();
        n_vec++;
        if ({a_dout, a_busy} !== {16'd4, 1'b1}) begin
            $display("FAIL run_dec: got dout=%h busy=%b expected 0004 1", a_dout, a_busy);
            n_err++;
        end
        a_dec = 1'b0; a_inc = 1'b1;
        tick();
        n_vec++;
        if ({a_dout, a_busy} !== {16'd3, 1'b1}) begin
            $display("FAIL run_inc: got dout=%h busy=%b expected 0003 1", a_dout, a_busy);
            n_err++;
        end
        a_inc = 1'b0; a_load = 1'b1; a_din = 16'd9;
        tick();
        a_load = 1'b0;
        n_vec++;
        if ({a_dout, a_busy, a_done} !== {16'd9, 1'b0, 1'b0}) begin
            $display("FAIL run_abort: got dout=%h busy=%b done=%b expected 0009 0 0", a_dout, a_busy, a_done);
            n_err++;
        end
        tick();
        n_vec++;
        if ({a_dout, a_busy, a_done} !== {16'd9, 1'b0, 1'b0}) begin
            $display("FAIL abort_hold: got dout=%h busy=%b done=%b expected 0009 0 0", a_dout, a_busy, a_done);
            n_err++;
        end
        a_load = 1'b1; a_start = 1'b1; a_din = 16'd7;
        tick();
        {a_load, a_start} = 2'b00;
        tick();
        n_vec++;
        if ({a_dout, a_busy} !== {16'd7, 1'b0}) begin
            $display("FAIL load_over_start: got dout=%h busy=%b expected 0007 0", a_dout, a_busy);
            n_err++;
        end
        a_start = 1'b1; a_din = 16'd5;
        tick();
        a_din = 16'd8;
        tick();
        a_start = 1'b0;
        n_vec++;
        if ({a_dout, a_busy} !== {16'd8, 1'b1}) begin
            $display("FAIL restart: got dout=%h busy=%b expected 0008 1", a_dout, a_busy);
            n_err++;
        end
        tick();
        n_vec++;
        if (a_dout !== 16'd7) begin
            $display("FAIL restart_tick: got %h expected 0007", a_dout);
            n_err++;
        end
    endtask

    task automatic test_async_reset();
        a_start = 1'b1; a_din = 16'd5;
        tick();
        a_start = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({a_dout, a_zero, a_busy, a_done} !== {16'd0, 1'b1, 1'b0, 1'b0}) begin
            $display("FAIL async_reset: got dout=%h zero=%b busy=%b done=%b expected 0000 1 0 0",
                     a_dout, a_zero, a_busy, a_done);
            n_err++;
        end
        #1;
        rst_n = 1'b1;
        tick();
        n_vec++;
        if ({a_dout, a_busy, a_done} !== {16'd0, 1'b0, 1'b0}) begin
            $display("FAIL post_reset_idle: got dout=%h busy=%b done=%b expected 0000 0 0", a_dout, a_busy, a_done);
            n_err++;
        end
        a_start = 1'b1; a_din = 16'd2;
        tick();
        a_start = 1'b0;
        n_vec++;
        if ({a_dout, a_busy} !== {16'd2, 1'b1}) begin
            $display("FAIL post_reset_start: got dout=%h busy=%b expected 0002 1", a_dout, a_busy);
            n_err++;
        end
        tick();
        tick();
        n_vec++;
        if ({a_dout, a_busy, a_done} !== {16'd0, 1'b0, 1'b1}) begin
            $display("FAIL post_reset_done: got dout=%h busy=%b done=%b expected 0000 0 1", a_dout, a_busy, a_done);
            n_err++;
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        idle_all();
        a_din = '0; s_din = '0; f_din = '0;
        tick();
        tick();
        test_reset();
        rst_n = 1'b1;
        tick();
        test_reset();
        test_load_manual();
        test_wrap_saturate();
        test_countdown();
        test_step4();
        test_priority();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
